sprite_line_drafter: RTL
========================

# sprite_line_drafter

Initiator side of the sprite column-count handshake. For each sprite descriptor offered for the scanline being prepared, it checks vertical overlap and drives `sprite_on` to the sprite line counter. It uses the returned column index to fetch 20 pixels of the sprite row from sprite memory, then writes the non-transparent, on-screen pixels into the scanline buffer. It sits between the sprite descriptor list and the line buffer, in the `clk_pixel` domain.

## Interface
- `SPRITE_W`, 20: sprite width and height in pixels; must match the line counter's 20-state cycle.
- `ADDR_W`, 14: sprite memory address width.
- `X_W`, 10: horizontal coordinate width.
- `Y_W`, 10: vertical coordinate width.
- `COLOR_W`, 9: pixel width.
- `TRANSPARENT`, 9'h1FF: pixel value that is never written.
- `H_ACTIVE`, 640: first invisible x coordinate.

Ports:
- `clk_pixel` in 1: pixel clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `line_y` in Y_W: scanline being prepared; stable while busy.
- `spr_valid` in 1 / `spr_ready` out 1: descriptor handshake; a transfer happens on an edge where both are high.
- `spr_x` in X_W, `spr_y` in Y_W, `spr_base` in ADDR_W, `spr_last` in 1: descriptor fields. `spr_last` marks the final descriptor of the line.
- `sprite_on` out 1: enable to the sprite line counter.
- `col_index` in 5: counter's current column, 0..19.
- `mem_addr` out ADDR_W: sprite memory read address, combinational.
- `mem_data` in COLOR_W: sprite memory data, one cycle of latency.
- `lb_we` out 1, `lb_addr` out X_W, `lb_data` out COLOR_W: line buffer write port, registered.
- `line_done` out 1: one-cycle pulse after the last descriptor has been fully handled.

## Operation
- States: IDLE, CHECK, DRAW, FLUSH, DONE.
- IDLE:
  - `spr_ready`=1.
  - On a transfer, latch x, y, base, last, then go to CHECK.
- CHECK (1 cycle):
  - `diff = line_y - spr_y` is computed in Y_W+1 bits.
  - Hit when `line_y >= spr_y` and `diff < 20`. Then `row = diff[4:0]`, `row_base = spr_base + row*20` (mod 2^ADDR_W), go to DRAW.
  - On a miss: go to DONE if last, else IDLE. No memory or buffer activity occurs.
- DRAW:
  - `sprite_on`=1.
  - `mem_addr = row_base + col_index` (mod 2^ADDR_W).
  - The edge that samples `col_index`=19 leaves for FLUSH.
- FLUSH (1 cycle): `sprite_on`=0. Go to DONE if last, else IDLE.
- DONE (1 cycle): `line_done`=1, then go to IDLE.
- Pixel pipeline: `mem_data` for column c is sampled one edge after its address. At that same edge:
  - `lb_addr` ← `spr_x + c`.
  - `lb_data` ← `mem_data`.
  - `lb_we` ← 1 only if `mem_data != TRANSPARENT` and `spr_x + c < H_ACTIVE`. The sum is computed in X_W+1 bits, so there is no wrap.
- `lb_we` is 0 in every other cycle.
- Counter contract:
  - Once `sprite_on` rises, `col_index` is 0 at the 1st following edge, 1 at the 2nd, …, 19 at the 20th.
  - With `sprite_on` low, `col_index` returns to 0.
  - The block relies only on `col_index`; the counter's `count_finished` is not used.
- `spr_ready`=0 in every state except IDLE.
- Later sprites overwrite earlier ones at the same x: last writer wins.

## Timing
- Reset values: state IDLE, `spr_ready`=1, `sprite_on`=0, `lb_we`=0, `lb_addr`=0, `lb_data`=0, `line_done`=0, and `mem_addr` = `row_base` + `col_index` with `row_base`=0.
- Hit sprite, accepted at edge A:
  - CHECK during A..A+1.
  - `sprite_on` high from A+1 until the edge A+21.
  - Columns 0..19 are addressed at edges A+2..A+21.
  - `lb_*` for column c is valid during the cycle after edge A+3+c; 20 consecutive cycles of potential writes.
  - FLUSH occupies A+21..A+22.
  - Next descriptor accepted at edge A+23 at the earliest, since IDLE is entered at A+22.
- Missed sprite: accepted at A, back in IDLE after A+1, next accept at A+2.
- `line_done` high for exactly one cycle, the cycle after the last descriptor's FLUSH or CHECK-miss.
- `reset` mid-DRAW: on the next edge all outputs take their reset values. Any in-flight pixel is dropped and no `line_done` is issued.
- `spr_valid` held high in IDLE is accepted on the first edge. Descriptor fields are ignored outside IDLE.

## Test plan
- Hit, opaque: `line_y`=100, sprite (x=50, y=95, base=0), memory word n = n[8:0] → row 5; `mem_addr` 100..119; writes at lb_addr 50..69 with data 100..119; `line_done` 1 cycle later.
- Vertical miss: `line_y`=100, `spr_y`=101, then `spr_y`=80 (diff=20), both last → no `sprite_on`, no writes, `line_done` 2 cycles after the accept.
- Transparency and right clip: x=630, columns 3 and 4 = 9'h1FF → exactly 8 writes, at lb_addr 630,631,632,635..639.
- Back-to-back: two hit sprites, x=0 and x=10, overlapping, `spr_valid` held high → second accept 23 cycles after the first; lb_addr 10..19 written last by sprite 2; single `line_done`.
- Reset at DRAW column 7 → next cycle `sprite_on`=0, `lb_we`=0, `spr_ready`=1, no `line_done`. A fresh descriptor then completes normally.
- Address wrap: base=16370, row=0 → `mem_addr` 16370..16383 then 0..5.

Source files
------------

// File: rtl/sprite_line_drafter.sv
// sprite_line_drafter: per-scanline sprite row fetch and line-buffer writer
module sprite_line_drafter #(
   parameter int                 SPRITE_W    = 20,
   parameter int                 ADDR_W      = 14,
   parameter int                 X_W         = 10,
   parameter int                 Y_W         = 10,
   parameter int                 COLOR_W     = 9,
   parameter logic [COLOR_W-1:0] TRANSPARENT = 9'h1FF,
   parameter int                 H_ACTIVE    = 640
) (
   input  logic               clk_pixel,
   input  logic               reset,
   input  logic [Y_W-1:0]     line_y,
   input  logic               spr_valid,
   output logic               spr_ready,
   input  logic [X_W-1:0]     spr_x,
   input  logic [Y_W-1:0]     spr_y,
   input  logic [ADDR_W-1:0]  spr_base,
   input  logic               spr_last,
   output logic               sprite_on,
   input  logic [4:0]         col_index,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [COLOR_W-1:0] mem_data,
   output logic               lb_we,
   output logic [X_W-1:0]     lb_addr,
   output logic [COLOR_W-1:0] lb_data,
   output logic               line_done
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CHECK = 3'd1;
   localparam logic [2:0] DRAW  = 3'd2;
   localparam logic [2:0] FLUSH = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]         state_q, state_d;
   logic [X_W-1:0]     x_q, x_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic               last_q, last_d;
   logic [ADDR_W-1:0]  row_base_q, row_base_d;
   logic               pend_q, pend_d;
   logic [X_W:0]       px_q, px_d;
   logic               lb_we_q, lb_we_d;
   logic [X_W-1:0]     lb_addr_q, lb_addr_d;
   logic [COLOR_W-1:0] lb_data_q, lb_data_d;

   logic [Y_W:0]       diff;
   logic               hit;
   logic [ADDR_W-1:0]  row_off;
   logic               col_end;

   assign diff      = {1'b0, line_y} - {1'b0, y_q};
   assign hit       = (line_y >= y_q) && (diff < (Y_W+1)'(SPRITE_W));
   assign row_off   = ADDR_W'(diff[4:0]) * ADDR_W'(SPRITE_W);
   assign col_end   = col_index == 5'(SPRITE_W - 1);

   assign spr_ready = state_q == IDLE;
   assign sprite_on = state_q == DRAW;
   assign line_done = state_q == DONE;
   assign mem_addr  = row_base_q + ADDR_W'(col_index);
   assign lb_we     = lb_we_q;
   assign lb_addr   = lb_addr_q;
   assign lb_data   = lb_data_q;

   // descriptor sequencing: accept, vertical test, row draw, drain, end-of-line pulse
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      base_d     = base_q;
      last_d     = last_q;
      row_base_d = row_base_q;
      case (state_q)
         IDLE: if (spr_valid) begin
            x_d     = spr_x;
            y_d     = spr_y;
            base_d  = spr_base;
            last_d  = spr_last;
            state_d = CHECK;
         end
         CHECK: if (hit) begin
            row_base_d = base_q + row_off;
            state_d    = DRAW;
         end else begin
            state_d = last_q ? DONE : IDLE;
         end
         DRAW:    state_d = col_end ? FLUSH : DRAW;
         FLUSH:   state_d = last_q ? DONE : IDLE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // pixel pipeline: remember the screen x of the column just addressed, write when its data returns
   always_comb begin
      pend_d    = state_q == DRAW;
      px_d      = {1'b0, x_q} + (X_W+1)'(col_index);
      lb_we_d   = pend_q && (mem_data != TRANSPARENT) && (px_q < (X_W+1)'(H_ACTIVE));
      lb_addr_d = pend_q ? px_q[X_W-1:0] : lb_addr_q;
      lb_data_d = pend_q ? mem_data : lb_data_q;
   end

   // state and pipeline registers; reset drops any in-flight pixel
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         base_q     <= '0;
         last_q     <= 1'b0;
         row_base_q <= '0;
         pend_q     <= 1'b0;
         px_q       <= '0;
         lb_we_q    <= 1'b0;
         lb_addr_q  <= '0;
         lb_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         base_q     <= base_d;
         last_q     <= last_d;
         row_base_q <= row_base_d;
         pend_q     <= pend_d;
         px_q       <= px_d;
         lb_we_q    <= lb_we_d;
         lb_addr_q  <= lb_addr_d;
         lb_data_q  <= lb_data_d;
      end
   end
endmodule
